// File: rtl/hamming_pkg.sv
// Shared Hamming(21,16) constants and helpers for the encoder/decoder pair.
// Codeword bit i carries Hamming position i+1; parity sits at the power-of-two positions.
package hamming_pkg;

    localparam int unsigned CW_W   = 21;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SYN_W  = 5;

    // Codeword bit index of each parity bit p1..p5.
    localparam int unsigned P1_BIT = 0;
    localparam int unsigned P2_BIT = 1;
    localparam int unsigned P3_BIT = 3;
    localparam int unsigned P4_BIT = 7;
    localparam int unsigned P5_BIT = 15;

    localparam logic [CW_W-1:0] PARITY_MASK = CW_W'((1 << P1_BIT) | (1 << P2_BIT) |
                                                   (1 << P3_BIT) | (1 << P4_BIT) |
                                                   (1 << P5_BIT));

    // Highest syndrome that names a real codeword position.
    localparam logic [SYN_W-1:0] SYN_MAX = SYN_W'(CW_W);

    // Mask k selects every position whose index has bit k set, parity bit included.
    localparam logic [CW_W-1:0] SYN_MASK [SYN_W] = '{
        21'h155555,
        21'h066666,
        21'h187878,
        21'h007F80,
        21'h1F8000
    };

    function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] syn;
        syn = '0;
        for (int unsigned k = 0; k < SYN_W; k++) begin
            syn[k] = ^(cw & SYN_MASK[k]);
        end
        return syn;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        return {cw[20:16], cw[14:8], cw[6:4], cw[2]};
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator: 21-bit codeword in, 5-bit syndrome out.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  codeword,
    output logic [SYN_W-1:0] syndrome
);

    assign syndrome = calc_syndrome(codeword);

endmodule

// File: rtl/hamming_decoder.sv
// Hamming(21,16) receive decoder: 2-stage elastic pipeline with single-bit correction
// and saturating corrected/uncorrectable word counters.
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW_W-1:0]   in_codeword,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              stat_clear,
    output logic [CNT_W-1:0]  corrected_cnt,
    output logic [CNT_W-1:0]  uncorrectable_cnt
);

    logic              s1_valid_q;
    logic [CW_W-1:0]   s1_cw_q;
    logic [SYN_W-1:0]  s1_syn_q;
    logic [SYN_W-1:0]  in_syn;
    logic              s1_adv;
    logic              s2_load;
    logic [CW_W-1:0]   fixed_cw;
    logic              fix_corr;
    logic              fix_unc;

    hamming_syndrome u_syndrome (
        .codeword (in_codeword),
        .syndrome (in_syn)
    );

    assign s1_adv   = !out_valid | out_ready;
    assign in_ready = !s1_valid_q | s1_adv;
    assign s2_load  = s1_adv & s1_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= '0;
            s1_syn_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_cw_q  <= in_codeword;
                s1_syn_q <= in_syn;
            end
        end
    end

    always_comb begin
        fixed_cw = s1_cw_q;
        fix_corr = 1'b0;
        fix_unc  = 1'b0;
        if (s1_syn_q != '0) begin
            if (s1_syn_q <= SYN_MAX) begin
                fix_corr = 1'b1;
                for (int unsigned i = 0; i < CW_W; i++) begin
                    if (s1_syn_q == SYN_W'(i + 1)) begin
                        fixed_cw[i] = ~s1_cw_q[i];
                    end
                end
            end else begin
                fix_unc = 1'b1;
            end
        end
    end

    // Stage 2 doubles as the output register, so it holds whenever the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_data          <= extract_data(fixed_cw);
                out_corrected     <= fix_corr;
                out_uncorrectable <= fix_unc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stat_clear) begin
            corrected_cnt     <= '0;
            uncorrectable_cnt <= '0;
        end else begin
            if (s2_load && fix_corr && (corrected_cnt != '1)) begin
                corrected_cnt <= corrected_cnt + 1'b1;
            end
            if (s2_load && fix_unc && (uncorrectable_cnt != '1)) begin
                uncorrectable_cnt <= uncorrectable_cnt + 1'b1;
            end
        end
    end

endmodule
